reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 182 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire of out-of-order results, with store
// handshake, register commit, branch predictor update and mispredict flush.
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int IDW   = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   output logic            rob_full,
   output logic [IDW:0]    rob_count,
   input  logic            disp_valid,
   input  logic [XLEN-1:0] disp_pc,
   input  logic [4:0]      disp_rd,
   input  logic            disp_is_br,
   input  logic            disp_pred_taken,
   input  logic            disp_is_store,
   output logic [IDW-1:0]  disp_tag,
   input  logic [IDW-1:0]  q1_tag,
   input  logic [IDW-1:0]  q2_tag,
   output logic            q1_rdy,
   output logic            q2_rdy,
   output logic [XLEN-1:0] q1_val,
   output logic [XLEN-1:0] q2_val,
   input  logic            cdb0_valid,
   input  logic [IDW-1:0]  cdb0_tag,
   input  logic [XLEN-1:0] cdb0_val,
   input  logic            cdb0_taken,
   input  logic [XLEN-1:0] cdb0_target,
   input  logic            cdb1_valid,
   input  logic [IDW-1:0]  cdb1_tag,
   input  logic [XLEN-1:0] cdb1_val,
   output logic            store_commit_req,
   input  logic            store_commit_ack,
   output logic            commit_valid,
   output logic [4:0]      commit_rd,
   output logic [XLEN-1:0] commit_val,
   output logic [IDW-1:0]  commit_tag,
   output logic            pred_upd_valid,
   output logic [XLEN-1:0] pred_upd_pc,
   output logic            pred_upd_taken,
   output logic            pred_upd_correct,
   output logic            flush,
   output logic [XLEN-1:0] flush_pc
);

   localparam logic [IDW:0] FULL_CNT = (IDW+1)'(DEPTH);

   logic [IDW-1:0]  head_reg, tail_reg;
   logic [IDW:0]    count_reg;
   logic [DEPTH-1:0] ready_reg;
   logic            commit_valid_reg, pred_upd_valid_reg, flush_reg;
   logic [4:0]      commit_rd_reg;
   logic [XLEN-1:0] commit_val_reg, pred_upd_pc_reg, flush_pc_reg;
   logic [IDW-1:0]  commit_tag_reg;
   logic            pred_upd_taken_reg, pred_upd_correct_reg;

   logic [XLEN-1:0] pc_mem     [DEPTH];
   logic [4:0]      rd_mem     [DEPTH];
   logic            is_br_mem  [DEPTH];
   logic            pred_mem   [DEPTH];
   logic            is_st_mem  [DEPTH];
   logic [XLEN-1:0] val_mem    [DEPTH];
   logic            taken_mem  [DEPTH];
   logic [XLEN-1:0] target_mem [DEPTH];

   logic alloc, retire, head_ready, head_store, head_br, mispredict;

   assign rob_full   = (count_reg == FULL_CNT);
   assign rob_count  = count_reg;
   assign disp_tag   = tail_reg;
   assign head_ready = (count_reg != '0) && ready_reg[head_reg];
   assign head_store = is_st_mem[head_reg];
   assign head_br    = is_br_mem[head_reg];

   // Nothing moves during the flush cycle; the whole window is discarded.
   assign alloc      = rdy && !flush_reg && disp_valid && !rob_full;
   assign retire     = rdy && !flush_reg && head_ready && (!head_store || store_commit_ack);
   assign mispredict = retire && head_br && (pred_mem[head_reg] != taken_mem[head_reg]);

   assign store_commit_req = head_ready && head_store && !flush_reg;

   // Operand lookup: cdb0 beats cdb1 beats stored state.
   logic [1:0][IDW-1:0]  q_tag;
   logic [1:0]           q_rdy;
   logic [1:0][XLEN-1:0] q_val;
   assign q_tag = {q2_tag, q1_tag};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
         always_comb begin
            q_rdy[gi] = ready_reg[q_tag[gi]];
            q_val[gi] = val_mem[q_tag[gi]];
            if (cdb1_valid && cdb1_tag == q_tag[gi]) begin
               q_rdy[gi] = 1'b1;
               q_val[gi] = cdb1_val;
            end
            if (cdb0_valid && cdb0_tag == q_tag[gi]) begin
               q_rdy[gi] = 1'b1;
               q_val[gi] = cdb0_val;
            end
         end
      end
   endgenerate

   assign q1_rdy = q_rdy[0];
   assign q2_rdy = q_rdy[1];
   assign q1_val = q_val[0];
   assign q2_val = q_val[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg           <= '0;
         tail_reg           <= '0;
         count_reg          <= '0;
         ready_reg          <= '0;
         commit_valid_reg   <= 1'b0;
         pred_upd_valid_reg <= 1'b0;
         flush_reg          <= 1'b0;
      end else if (rdy) begin
         commit_valid_reg   <= retire && !head_br && !head_store && (rd_mem[head_reg] != 5'd0);
         pred_upd_valid_reg <= retire && head_br;
         flush_reg          <= mispredict;
         if (flush_reg) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            ready_reg <= '0;
         end else begin
            if (alloc)  tail_reg <= tail_reg + 1'b1;
            if (retire) head_reg <= head_reg + 1'b1;
            count_reg <= count_reg + (IDW+1)'(alloc) - (IDW+1)'(retire);
            if (cdb1_valid) ready_reg[cdb1_tag] <= 1'b1;
            if (cdb0_valid) ready_reg[cdb0_tag] <= 1'b1;
            // A broadcast to a slot being reallocated is stale; allocation wins.
            if (alloc)      ready_reg[tail_reg] <= 1'b0;
         end
      end
   end

   // Payload storage and retire-side data registers carry no reset.
   always_ff @(posedge clk) begin
      if (rdy && !flush_reg) begin
         if (alloc) begin
            pc_mem[tail_reg]    <= disp_pc;
            rd_mem[tail_reg]    <= disp_rd;
            is_br_mem[tail_reg] <= disp_is_br;
            pred_mem[tail_reg]  <= disp_pred_taken;
            is_st_mem[tail_reg] <= disp_is_store;
         end
         if (cdb1_valid) val_mem[cdb1_tag] <= cdb1_val;
         if (cdb0_valid) begin
            val_mem[cdb0_tag]    <= cdb0_val;
            taken_mem[cdb0_tag]  <= cdb0_taken;
            target_mem[cdb0_tag] <= cdb0_target;
         end
         if (retire) begin
            commit_rd_reg        <= rd_mem[head_reg];
            commit_val_reg       <= val_mem[head_reg];
            commit_tag_reg       <= head_reg;
            pred_upd_pc_reg      <= pc_mem[head_reg];
            pred_upd_taken_reg   <= taken_mem[head_reg];
            pred_upd_correct_reg <= (pred_mem[head_reg] == taken_mem[head_reg]);
            flush_pc_reg         <= taken_mem[head_reg] ? target_mem[head_reg]
                                                        : pc_mem[head_reg] + XLEN'(4);
         end
      end
   end

   assign commit_valid     = commit_valid_reg && rdy;
   assign commit_rd        = commit_rd_reg;
   assign commit_val       = commit_val_reg;
   assign commit_tag       = commit_tag_reg;
   assign pred_upd_valid   = pred_upd_valid_reg && rdy;
   assign pred_upd_pc      = pred_upd_pc_reg;
   assign pred_upd_taken   = pred_upd_taken_reg;
   assign pred_upd_correct = pred_upd_correct_reg;
   assign flush            = flush_reg && rdy;
   assign flush_pc         = flush_pc_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expected commit/predictor/flush events are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_reorder_buffer;
   localparam int DEPTH = 16;
   localparam int IDW   = 4;
   localparam int XLEN  = 32;

   logic            clk = 1'b0;
   logic            rst, rdy;
   logic            rob_full;
   logic [IDW:0]    rob_count;
   logic            disp_valid, disp_is_br, disp_pred_taken, disp_is_store;
   logic [XLEN-1:0] disp_pc;
   logic [4:0]      disp_rd;
   logic [IDW-1:0]  disp_tag, q1_tag, q2_tag;
   logic            q1_rdy, q2_rdy;
   logic [XLEN-1:0] q1_val, q2_val;
   logic            cdb0_valid, cdb0_taken, cdb1_valid;
   logic [IDW-1:0]  cdb0_tag, cdb1_tag;
   logic [XLEN-1:0] cdb0_val, cdb0_target, cdb1_val;
   logic            store_commit_req, store_commit_ack;
   logic            commit_valid;
   logic [4:0]      commit_rd;
   logic [XLEN-1:0] commit_val;
   logic [IDW-1:0]  commit_tag;
   logic            pred_upd_valid, pred_upd_taken, pred_upd_correct;
   logic [XLEN-1:0] pred_upd_pc;
   logic            flush;
   logic [XLEN-1:0] flush_pc;

   reorder_buffer #(.DEPTH(DEPTH), .IDW(IDW), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_full(rob_full), .rob_count(rob_count),
      .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_rd(disp_rd),
      .disp_is_br(disp_is_br), .disp_pred_taken(disp_pred_taken),
      .disp_is_store(disp_is_store), .disp_tag(disp_tag),
      .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_rdy(q1_rdy), .q2_rdy(q2_rdy),
      .q1_val(q1_val), .q2_val(q2_val),
      .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
      .cdb0_taken(cdb0_taken), .cdb0_target(cdb0_target),
      .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
      .store_commit_req(store_commit_req), .store_commit_ack(store_commit_ack),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_tag(commit_tag),
      .pred_upd_valid(pred_upd_valid), .pred_upd_pc(pred_upd_pc),
      .pred_upd_taken(pred_upd_taken), .pred_upd_correct(pred_upd_correct),
      .flush(flush), .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] val;
      logic [IDW-1:0]  tag;
   } commit_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            taken;
      logic            correct;
   } pred_t;

   commit_t         commit_q[$];
   pred_t           pred_q[$];
   logic [XLEN-1:0] flush_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic dispatch(input logic [XLEN-1:0] pc, input logic [4:0] rd,
                           input logic br, input logic pred, input logic st);
      disp_pc = pc; disp_rd = rd; disp_is_br = br; disp_pred_taken = pred; disp_is_store = st;
      disp_valid = 1'b1;
      tick();
      disp_valid = 1'b0;
      $display("dispatch pc=%h rd=%0d br=%0d st=%0d -> count=%0d", pc, rd, br, st, rob_count);
   endtask

   task automatic bcast0(input logic [IDW-1:0] tag, input logic [XLEN-1:0] val,
                         input logic taken, input logic [XLEN-1:0] target);
      cdb0_tag = tag; cdb0_val = val; cdb0_taken = taken; cdb0_target = target;
      cdb0_valid = 1'b1;
      tick();
      cdb0_valid = 1'b0;
      $display("cdb0 tag=%0d val=%h taken=%0d target=%h", tag, val, taken, target);
   endtask

   task automatic bcast1(input logic [IDW-1:0] tag, input logic [XLEN-1:0] val);
      cdb1_tag = tag; cdb1_val = val;
      cdb1_valid = 1'b1;
      tick();
      cdb1_valid = 1'b0;
      $display("cdb1 tag=%0d val=%h", tag, val);
   endtask

   // Monitor: every output pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (commit_valid) begin
         if (commit_q.size() == 0) chk("commit_unexpected", {commit_rd, commit_val, commit_tag}, 64'h0);
         else chk("commit", {commit_rd, commit_val, commit_tag}, commit_q.pop_front());
         $display("commit rd=%0d val=%h tag=%0d", commit_rd, commit_val, commit_tag);
      end
      if (pred_upd_valid) begin
         if (pred_q.size() == 0) chk("pred_unexpected", {pred_upd_pc, pred_upd_taken, pred_upd_correct}, 64'h0);
         else chk("pred_upd", {pred_upd_pc, pred_upd_taken, pred_upd_correct}, pred_q.pop_front());
         $display("pred_upd pc=%h taken=%0d correct=%0d", pred_upd_pc, pred_upd_taken, pred_upd_correct);
      end
      if (flush) begin
         if (flush_q.size() == 0) chk("flush_unexpected", {1'b1, flush_pc}, 64'h0);
         else chk("flush_pc", flush_pc, flush_q.pop_front());
         $display("flush pc=%h", flush_pc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IDW-1:0] t;
      rst = 1'b1; rdy = 1'b1;
      disp_valid = 0; disp_pc = '0; disp_rd = '0; disp_is_br = 0; disp_pred_taken = 0; disp_is_store = 0;
      q1_tag = '0; q2_tag = '0;
      cdb0_valid = 0; cdb0_tag = '0; cdb0_val = '0; cdb0_taken = 0; cdb0_target = '0;
      cdb1_valid = 0; cdb1_tag = '0; cdb1_val = '0;
      store_commit_ack = 0;
      do_reset();

      // Reset state
      chk("reset_count", rob_count, 0);
      chk("reset_full", rob_full, 0);
      chk("reset_disp_tag", disp_tag, 0);
      chk("reset_store_req", store_commit_req, 0);
      chk("reset_flush", flush, 0);

      // Fill, overflow, free one slot, wrap
      for (int i = 0; i < DEPTH; i++) dispatch(32'h1000 + 32'(i * 4), 5'd1, 0, 0, 0);
      chk("fill_full", rob_full, 1);
      chk("fill_count", rob_count, 16);
      dispatch(32'h2000, 5'd1, 0, 0, 0);
      chk("overflow_count", rob_count, 16);
      chk("overflow_tail", disp_tag, 0);
      commit_q.push_back('{rd: 5'd1, val: 32'h55, tag: 4'd0});
      bcast0(4'd0, 32'h55, 0, 32'h0);
      tick();
      chk("after_retire_count", rob_count, 15);
      chk("after_retire_full", rob_full, 0);
      chk("wrap_tag", disp_tag, 0);
      dispatch(32'h3000, 5'd1, 0, 0, 0);
      chk("refill_count", rob_count, 16);
      do_reset();

      // Same-cycle CDB bypass and stored lookup
      for (int i = 0; i < 3; i++) dispatch(32'h40 + 32'(i * 4), 5'd0, 0, 0, 0);
      disp_pc = 32'h4c; disp_rd = 5'd0; disp_valid = 1'b1;
      cdb1_valid = 1'b1; cdb1_tag = 4'd3; cdb1_val = 32'hDEAD; q1_tag = 4'd3;
      #1;
      chk("bypass_tag", disp_tag, 3);
      chk("bypass_cdb1_rdy", q1_rdy, 1);
      chk("bypass_cdb1_val", q1_val, 32'hDEAD);
      cdb0_valid = 1'b1; cdb0_tag = 4'd3; cdb0_val = 32'hBEEF; q2_tag = 4'd3;
      #1;
      chk("bypass_cdb0_prio", q1_val, 32'hBEEF);
      chk("bypass_q2_rdy", q2_rdy, 1);
      chk("bypass_q2_val", q2_val, 32'hBEEF);
      q1_tag = 4'd1;
      #1;
      chk("lookup_not_ready", q1_rdy, 0);
      tick();
      disp_valid = 0; cdb0_valid = 0; cdb1_valid = 0;
      $display("bypass dispatch tag3 done, count=%0d", rob_count);
      bcast0(4'd1, 32'h1234, 0, 32'h0);
      q1_tag = 4'd1;
      #1;
      chk("stored_rdy", q1_rdy, 1);
      chk("stored_val", q1_val, 32'h1234);
      do_reset();

      // Store handshake
      dispatch(32'h500, 5'd0, 0, 0, 1);
      bcast1(4'd0, 32'h99);
      for (int i = 0; i < 5; i++) begin
         chk("store_req_wait", store_commit_req, 1);
         chk("store_hold_count", rob_count, 1);
         tick();
      end
      store_commit_ack = 1'b1;
      chk("store_req_ack", store_commit_req, 1);
      tick();
      store_commit_ack = 1'b0;
      chk("store_retired_count", rob_count, 0);
      chk("store_req_cleared", store_commit_req, 0);
      do_reset();

      // Register commit and silent rd=0 retire
      dispatch(32'h10, 5'd5, 0, 0, 0);
      dispatch(32'h14, 5'd0, 0, 0, 0);
      commit_q.push_back('{rd: 5'd5, val: 32'd7, tag: 4'd0});
      bcast0(4'd0, 32'd7, 0, 32'h0);
      bcast1(4'd1, 32'd9);
      tick();
      tick();
      chk("commit_drain_count", rob_count, 0);
      do_reset();

      // Taken mispredict with dispatch attempted during the flush cycle
      dispatch(32'h100, 5'd0, 1, 0, 0);
      dispatch(32'h104, 5'd3, 0, 0, 0);
      pred_q.push_back('{pc: 32'h100, taken: 1'b1, correct: 1'b0});
      flush_q.push_back(32'h200);
      bcast0(4'd0, 32'h0, 1, 32'h200);
      tick();
      chk("mp_flush", flush, 1);
      chk("mp_flush_pc", flush_pc, 32'h200);
      chk("mp_correct", pred_upd_correct, 0);
      disp_valid = 1'b1;
      tick();
      disp_valid = 1'b0;
      chk("mp_count_cleared", rob_count, 0);
      chk("mp_flush_done", flush, 0);
      chk("mp_tail_cleared", disp_tag, 0);

      // Correct prediction: update only, no flush
      dispatch(32'h40, 5'd0, 1, 1, 0);
      pred_q.push_back('{pc: 32'h40, taken: 1'b1, correct: 1'b1});
      bcast0(4'd0, 32'h0, 1, 32'h80);
      tick();
      tick();
      chk("okbr_count", rob_count, 0);
      chk("okbr_no_flush", flush, 0);

      // Not-taken mispredict at the top of the address space wraps to 0
      t = disp_tag;
      dispatch(32'hFFFF_FFFC, 5'd0, 1, 1, 0);
      pred_q.push_back('{pc: 32'hFFFF_FFFC, taken: 1'b0, correct: 1'b0});
      flush_q.push_back(32'h0);
      bcast0(t, 32'h0, 0, 32'h1234);
      tick();
      chk("nt_flush", flush, 1);
      tick();
      chk("nt_count_cleared", rob_count, 0);
      do_reset();

      // Pause with ready head, then resume
      dispatch(32'h20, 5'd2, 0, 0, 0);
      bcast0(4'd0, 32'h11, 0, 32'h0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_count", rob_count, 1);
      end
      disp_valid = 1'b1;
      tick();
      disp_valid = 1'b0;
      chk("pause_disp_ignored", rob_count, 1);
      chk("pause_tail_held", disp_tag, 1);
      commit_q.push_back('{rd: 5'd2, val: 32'h11, tag: 4'd0});
      rdy = 1'b1;
      tick();
      tick();
      chk("resume_count", rob_count, 0);
      do_reset();

      // Reset during a pending store handshake, with rdy low
      dispatch(32'h600, 5'd0, 0, 0, 1);
      bcast1(4'd0, 32'h77);
      chk("pre_rst_req", store_commit_req, 1);
      store_commit_ack = 1'b1; rdy = 1'b0; rst = 1'b1;
      tick();
      chk("rst_req", store_commit_req, 0);
      chk("rst_count", rob_count, 0);
      chk("rst_full", rob_full, 0);
      chk("rst_disp_tag", disp_tag, 0);
      rst = 1'b0; rdy = 1'b1; store_commit_ack = 1'b0;
      tick();
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_flush", flush, 0);
      tick();

      chk("commit_q_empty", commit_q.size(), 0);
      chk("pred_q_empty", pred_q.size(), 0);
      chk("flush_q_empty", flush_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
